quadrature_result_arbiter: RTL

Shares one result stream between NUM_CH quadrature decoder channels. Each channel produces three result kinds: phase offset, A pulse width and B pulse width. Results are captured into per-channel single-entry slots and drained round-robin onto one valid/ready output toward the register or DMA side. Sticky per-channel overflow flags report results that were overwritten before they could be drained.

---
 rtl/quadrature_result_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/quadrature_result_arbiter.sv
// rtl/quadrature_result_arbiter.sv - round-robin arbiter draining per-channel quadrature results onto one stream
// Optional feature macro: QUAD_ARB_TIMESTAMP_EN (adds m_timestamp and per-slot timestamp capture)
module quadrature_result_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int TS_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0]   phase_offset,
  input  logic [NUM_CH-1:0]                 phase_offset_valid,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0]   a_pulse_width,
  input  logic [NUM_CH-1:0]                 a_pulse_polarity,
  input  logic [NUM_CH-1:0]                 a_pulse_valid,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0]   b_pulse_width,
  input  logic [NUM_CH-1:0]                 b_pulse_polarity,
  input  logic [NUM_CH-1:0]                 b_pulse_valid,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_channel,
  output logic [1:0]                        m_kind,
  output logic                              m_polarity,
  output logic [COUNTER_WIDTH-1:0]          m_value,
`ifdef QUAD_ARB_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]               m_timestamp,
`endif
  output logic [NUM_CH-1:0]                 overflow,
  input  logic [NUM_CH-1:0]                 overflow_clr
);

  localparam int NS  = 3 * NUM_CH;
  localparam int PW  = $clog2(NS);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Flattened strobe/value view, slot index s = ch*3 + kind
  logic [NS-1:0]            strobe;
  logic [COUNTER_WIDTH-1:0] in_val [NS];
  logic [NS-1:0]            in_pol;

  // Slot storage
  logic [NS-1:0]            pend;
  logic [COUNTER_WIDTH-1:0] slot_val [NS];
  logic [NS-1:0]            slot_pol;

  // Arbitration
  logic [PW-1:0]            ptr;
  logic                     gnt_valid;
  logic [PW-1:0]            gnt_idx;
  logic [PW-1:0]            ptr_next;
  logic [CHW-1:0]           gnt_ch;
  logic [1:0]               gnt_kind;
  logic                     do_load;
  logic                     drain;
  logic [NUM_CH-1:0]        ovf_set;

`ifdef QUAD_ARB_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]      ts_cnt;
  logic [TS_WIDTH-1:0]      slot_ts [NS];
`endif

  // Map the three per-channel input kinds onto the flat slot index
  always_comb begin
    strobe = '0;
    in_pol = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      strobe[3*c]     = phase_offset_valid[c];
      strobe[3*c+1]   = a_pulse_valid[c];
      strobe[3*c+2]   = b_pulse_valid[c];
      in_val[3*c]     = phase_offset[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      in_val[3*c+1]   = a_pulse_width[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      in_val[3*c+2]   = b_pulse_width[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      in_pol[3*c]     = 1'b0;
      in_pol[3*c+1]   = a_pulse_polarity[c];
      in_pol[3*c+2]   = b_pulse_polarity[c];
    end
  end

  // Find the first pending slot at or above the pointer, wrapping around
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NS) idx = idx - NS;
      if (!gnt_valid && pend[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
  end

  // Decode the grant and decide whether the output register advances this edge
  always_comb begin
    gnt_ch   = CHW'(int'(gnt_idx) / 3);
    gnt_kind = 2'(int'(gnt_idx) % 3);
    ptr_next = (gnt_idx == PW'(NS - 1)) ? '0 : gnt_idx + 1'b1;
    do_load  = !m_valid || m_ready;
    drain    = do_load && gnt_valid;
  end

  // A strobe landing on a pending slot that is not leaving this edge loses the old result
  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (strobe[3*c+k] && pend[3*c+k] && !(drain && (gnt_idx == PW'(3*c+k))))
          ovf_set[c] = 1'b1;
      end
    end
  end

  // Pending flags: a new strobe always re-arms the slot, even when its old value drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (strobe[s])
          pend[s] <= 1'b1;
        else if (drain && (gnt_idx == PW'(s)))
          pend[s] <= 1'b0;
      end
    end
  end

  // Slot payload capture; newest strobe wins
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (strobe[s]) begin
        slot_val[s] <= in_val[s];
        slot_pol[s] <= in_pol[s];
      end
    end
  end

  // Round-robin pointer moves past each granted slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (drain)
      ptr <= ptr_next;
  end

  // Output register; fields hold while presented and not accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_channel  <= '0;
      m_kind     <= 2'd0;
      m_polarity <= 1'b0;
      m_value    <= '0;
    end else if (do_load) begin
      m_valid <= gnt_valid;
      if (gnt_valid) begin
        m_channel  <= gnt_ch;
        m_kind     <= gnt_kind;
        m_polarity <= slot_pol[gnt_idx];
        m_value    <= slot_val[gnt_idx];
      end
    end
  end

  // Sticky overflow; a same-edge overflow event beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= '0;
    else
      overflow <= (overflow & ~overflow_clr) | ovf_set;
  end

`ifdef QUAD_ARB_TIMESTAMP_EN
  // Free-running timestamp counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_cnt + 1'b1;
  end

  // Timestamp captured alongside the slot payload
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (strobe[s])
        slot_ts[s] <= ts_cnt;
    end
  end

  // Timestamp follows the output register load/hold behaviour
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      m_timestamp <= '0;
    else if (drain)
      m_timestamp <= slot_ts[gnt_idx];
  end
`endif

endmodule
